// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V fetch front-end: data width, base
// opcodes, fetch FSM states and the {pc, instr} queue entry.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
  localparam logic [6:0] OPC_I_TYPE = 7'b0010011;
  localparam logic [6:0] OPC_S_TYPE = 7'b0100011;
  localparam logic [6:0] OPC_B_TYPE = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // True for instructions that change control flow (branch, jal, jalr).
  function automatic logic is_ctrl_opcode(input logic [XLEN-1:0] instr);
    case (instr[6:0])
      OPC_B_TYPE, OPC_JAL, OPC_JALR: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Small synchronous FIFO of fetch entries. Flush empties it in one cycle and
// wins over push/pop. The head entry is read straight from the storage flops,
// so an empty FIFO never forwards a pushed entry in the same cycle.
module riscv_fetch_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push_s;
  logic          do_pop_s;

  assign do_pop_s  = pop && (count_q != {CW{1'b0}});
  assign do_push_s = push && ((count_q != FULL_COUNT) || do_pop_s);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = {PW{1'b0}};
      rptr_d  = {PW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_d[wptr_q] = push_entry;
        wptr_d        = wptr_q + PW'(1);
      end else begin
        wptr_d = wptr_q;
      end
      if (do_pop_s) begin
        rptr_d = rptr_q + PW'(1);
      end else begin
        rptr_d = rptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State flops; storage clears on reset so the head reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      wptr_q  <= {PW{1'b0}};
      rptr_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/riscv_fetch_queue.sv
// Instruction fetch front-end: issues word requests to instruction memory
// under a credit limit (outstanding + queued <= DEPTH), queues in-order
// responses as {pc, instr} and hands them to decode. A redirect flushes the
// queue, restarts fetch at the new pc and marks in-flight responses stale.
// Optional macro RISCV_FETCH_BRANCH_STALL_EN: a queued branch/jal/jalr stops
// fetch (HOLD) and drops responses issued behind it until the next redirect.
module riscv_fetch_queue
  import riscv_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;

  fetch_entry_t  fifo_head_s;
  fetch_entry_t  push_entry_s;
  logic [CW-1:0] fifo_count_s;
  logic [CW:0]   inflight_s;
  logic          push_s;
  logic          pop_s;
  logic          req_fire_s;
  logic [31:0]   redirect_target_s;
  logic          unused_redirect_lo;

  // Low redirect bits are dropped: fetch is always word aligned.
  assign redirect_target_s  = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lo = ^redirect_pc[1:0];

  // Responses still to come plus queued words may never exceed the queue size.
  assign inflight_s     = {1'b0, outstanding_q} + {1'b0, fifo_count_s};
  assign imem_req_valid = !rst && (state_q == FETCH) && !redirect_valid &&
                          (inflight_s < DEPTH_W);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire_s     = imem_req_valid && imem_req_ready;

  assign out_valid = (fifo_count_s != {CW{1'b0}}) && !redirect_valid;
  assign out_pc    = fifo_head_s.pc;
  assign out_instr = fifo_head_s.instr;
  assign pop_s     = out_valid && out_ready;

  assign push_entry_s = '{pc: resp_pc_q, instr: imem_rsp_data};

  // Next-state for fetch pointers, in-flight bookkeeping and the FSM.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    discard_d     = discard_q;
    push_s        = 1'b0;
    outstanding_d = outstanding_q + {{(CW-1){1'b0}}, req_fire_s}
                                  - {{(CW-1){1'b0}}, imem_rsp_valid};
    if (redirect_valid) begin
      // Everything still in flight belongs to the old path.
      fetch_pc_d = redirect_target_s;
      resp_pc_d  = redirect_target_s;
      discard_d  = outstanding_d;
      state_d    = FETCH;
    end else begin
      if (req_fire_s) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (imem_rsp_valid) begin
        if (discard_q != {CW{1'b0}}) begin
          discard_d = discard_q - CW'(1);
        end else begin
          push_s    = 1'b1;
          resp_pc_d = resp_pc_q + 32'd4;
`ifdef RISCV_FETCH_BRANCH_STALL_EN
          if (is_ctrl_opcode(imem_rsp_data)) begin
            // Words fetched behind a control transfer are speculative.
            state_d   = HOLD;
            discard_d = outstanding_d;
          end else begin
            state_d = state_q;
          end
`endif
        end
      end else begin
        discard_d = discard_q;
      end
    end
  end

  // Control state flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= {CW{1'b0}};
      discard_q     <= {CW{1'b0}};
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  riscv_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .flush      (redirect_valid),
    .head       (fifo_head_s),
    .count      (fifo_count_s)
  );

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Self-checking bench for riscv_fetch_queue. A transaction-level model (a
// queue of in-flight memory requests with stale flags and a queue of
// deliverable {pc, instr} words) predicts every handshake cycle by cycle.
module tb_riscv_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  riscv_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; bit stale; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  mreq_t       mq[$];
  ent_t        q[$];
  logic [31:0] exp_fetch;
  bit          hold;
  int          cyc;
  int          last_due;
  int          lat_lo, lat_hi;
  bit          special_en;
  logic [31:0] special_addr;
  int          vectors;
  int          miscompares;

  bit          obs_rv, obs_ov, obs_rfire, obs_ofire;
  logic [31:0] obs_addr, obs_pc, obs_instr;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (special_en && a == special_addr) return 32'h0000_0063;
    else return {a[26:2] ^ 25'h0A5_A5A5, 7'h13};
  endfunction

  task automatic step(input bit rd, input logic [31:0] rpc, input bit rr, input bit ordy);
    mreq_t       cur;
    mreq_t       nr;
    ent_t        e;
    bit          rsp;
    int          outst;
    int          d;
    logic [31:0] rdata;
    bit          exp_rv, exp_ov;
    @(negedge clk);
    cyc++;
    outst = mq.size();
    rsp   = 1'b0;
    rdata = 32'h0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      cur   = mq.pop_front();
      rsp   = 1'b1;
      rdata = mem_fn(cur.addr);
    end
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? rdata : 32'hDEAD_BEEF;
    redirect_valid = rd;
    redirect_pc    = rpc;
    imem_req_ready = rr;
    out_ready      = ordy;
    #1;
    obs_rv = imem_req_valid; obs_ov = out_valid;
    obs_addr = imem_req_addr; obs_pc = out_pc; obs_instr = out_instr;
    obs_rfire = obs_rv && rr; obs_ofire = obs_ov && ordy;

    exp_rv = !hold && !rd && (outst + q.size() < DEPTH);
    vectors++;
    if (imem_req_valid !== exp_rv) begin
      miscompares++;
      $display("FAIL req_valid: got %0b want %0b (cycle %0d)", imem_req_valid, exp_rv, cyc);
    end
    if (exp_rv && rr) begin
      vectors++;
      if (imem_req_addr !== exp_fetch) begin
        miscompares++;
        $display("FAIL req_addr: got %h want %h (cycle %0d)", imem_req_addr, exp_fetch, cyc);
      end
    end
    exp_ov = (q.size() != 0) && !rd;
    vectors++;
    if (out_valid !== exp_ov) begin
      miscompares++;
      $display("FAIL out_valid: got %0b want %0b (cycle %0d)", out_valid, exp_ov, cyc);
    end
    if (exp_ov) begin
      vectors++;
      if (out_pc !== q[0].pc || out_instr !== q[0].instr) begin
        miscompares++;
        $display("FAIL out_entry: got pc %h instr %h want pc %h instr %h (cycle %0d)",
                 out_pc, out_instr, q[0].pc, q[0].instr, cyc);
      end
    end

    if (rd) begin
      foreach (mq[i]) mq[i].stale = 1'b1;
      q.delete();
      exp_fetch = {rpc[31:2], 2'b00};
      hold      = 1'b0;
    end else begin
      if (exp_ov && ordy) e = q.pop_front();
      if (exp_rv && rr) begin
        d = cyc + $urandom_range(lat_hi, lat_lo);
        if (d <= last_due) d = last_due + 1;
        last_due  = d;
        nr.addr   = exp_fetch;
        nr.due    = d;
        nr.stale  = 1'b0;
        mq.push_back(nr);
        exp_fetch = exp_fetch + 32'd4;
      end
      if (rsp && !cur.stale) begin
        e.pc    = cur.addr;
        e.instr = rdata;
        q.push_back(e);
`ifdef RISCV_FETCH_BRANCH_STALL_EN
        if (rdata[6:0] == 7'h63 || rdata[6:0] == 7'h6F || rdata[6:0] == 7'h67) begin
          hold = 1'b1;
          foreach (mq[i]) mq[i].stale = 1'b1;
        end
`endif
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    #1;
    vectors++;
    if (imem_req_valid !== 1'b0 || out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state: got rv %0b ov %0b pc %h instr %h want all 0",
               imem_req_valid, out_valid, out_pc, out_instr);
    end
    repeat (2) @(negedge clk);
    mq.delete(); q.delete();
    hold = 1'b0; exp_fetch = RESET_PC; last_due = cyc;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    lat_lo = 1; lat_hi = 1;
    step(1'b0, 32'h0, 1'b1, 1'b1);
    vectors++;
    if (obs_rfire !== 1'b1 || obs_addr !== RESET_PC) begin
      miscompares++;
      $display("FAIL first_req: got fire %0b addr %h want 1 %h", obs_rfire, obs_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    apply_reset();
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1);
      vectors++;
      if (obs_rv !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_req_gap: got %0b want 1 (step %0d)", obs_rv, i);
      end
      if (i >= 2) begin
        vectors++;
        if (obs_ov !== 1'b1) begin
          miscompares++;
          $display("FAIL stream_out_gap: got %0b want 1 (step %0d)", obs_ov, i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int fires;
    int pops;
    bit got;
    apply_reset();
    lat_lo = 1; lat_hi = 1;
    fires = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      if (obs_rfire) fires++;
    end
    vectors++;
    if (fires !== 4 || obs_rv !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_credit: got %0d requests rv %0b want 4 and 0", fires, obs_rv);
    end
    pops = 0; got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1);
      if (i < 4 && obs_ofire) pops++;
      if (!got && obs_rfire) begin
        got = 1'b1;
        vectors++;
        if (obs_addr !== 32'h10) begin
          miscompares++;
          $display("FAIL bp_resume_addr: got %h want 00000010", obs_addr);
        end
      end
    end
    vectors++;
    if (pops !== 4 || !got) begin
      miscompares++;
      $display("FAIL bp_drain: got %0d pops resumed %0b want 4 and 1", pops, got);
    end
  endtask

  task automatic wait_first(input string name, input logic [31:0] want_addr, input logic [31:0] want_pc);
    bit got_r, got_o;
    got_r = 1'b0; got_o = 1'b0;
    for (int i = 0; i < 20 && !got_o; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1);
      if (!got_r && obs_rfire) begin
        got_r = 1'b1;
        vectors++;
        if (obs_addr !== want_addr) begin
          miscompares++;
          $display("FAIL %s_req: got %h want %h", name, obs_addr, want_addr);
        end
      end
      if (!got_o && obs_ofire) begin
        got_o = 1'b1;
        vectors++;
        if (obs_pc !== want_pc || obs_instr !== mem_fn(want_pc)) begin
          miscompares++;
          $display("FAIL %s_out: got pc %h instr %h want pc %h instr %h",
                   name, obs_pc, obs_instr, want_pc, mem_fn(want_pc));
        end
      end
    end
    vectors++;
    if (!got_o) begin
      miscompares++;
      $display("FAIL %s_timeout: got no delivery want pc %h", name, want_pc);
    end
  endtask

  task automatic test_redirect_stale();
    apply_reset();
    lat_lo = 3; lat_hi = 3;
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h43, 1'b1, 1'b1);
    wait_first("redir_stale", 32'h40, 32'h40);
  endtask

  task automatic test_redirect_collide();
    apply_reset();
    lat_lo = 2; lat_hi = 2;
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h100, 1'b1, 1'b1);
    vectors++;
    if (obs_ov !== 1'b0 || obs_rv !== 1'b0) begin
      miscompares++;
      $display("FAIL collide_cycle: got ov %0b rv %0b want 0 0", obs_ov, obs_rv);
    end
    wait_first("collide", 32'h100, 32'h100);
  endtask

  task automatic test_wrap();
    logic [31:0] addrs[4];
    logic [31:0] pcs[4];
    int na, np;
    apply_reset();
    lat_lo = 1; lat_hi = 1;
    step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    na = 0; np = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1);
      if (obs_rfire && na < 4) begin addrs[na] = obs_addr; na++; end
      if (obs_ofire && np < 4) begin pcs[np] = obs_pc; np++; end
    end
    vectors++;
    if (na < 2 || np < 2 || addrs[0] !== 32'hFFFF_FFFC || addrs[1] !== 32'h0 ||
        pcs[0] !== 32'hFFFF_FFFC || pcs[1] !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap: got req %h %h out %h %h want fffffffc 00000000 twice",
               addrs[0], addrs[1], pcs[0], pcs[1]);
    end
  endtask

`ifdef RISCV_FETCH_BRANCH_STALL_EN
  task automatic test_branch_stall();
    int  fires;
    bit  seen;
    apply_reset();
    lat_lo = 1; lat_hi = 1;
    special_en = 1'b1; special_addr = 32'h8;
    fires = 0; seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1);
      if (obs_rfire) fires++;
      if (obs_ofire && obs_pc === 32'h8 && obs_instr === 32'h0000_0063) seen = 1'b1;
    end
    vectors++;
    if (fires !== 4 || !seen) begin
      miscompares++;
      $display("FAIL branch_hold: got %0d requests beq_seen %0b want 4 and 1", fires, seen);
    end
    step(1'b1, 32'h20, 1'b1, 1'b1);
    special_en = 1'b0;
    wait_first("branch_resume", 32'h20, 32'h20);
  endtask
`endif

  task automatic test_async_reset();
    apply_reset();
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got ov %0b rv %0b want 0 0", out_valid, imem_req_valid);
    end
    apply_reset();
    step(1'b0, 32'h0, 1'b1, 1'b1);
    vectors++;
    if (obs_rfire !== 1'b1 || obs_addr !== RESET_PC) begin
      miscompares++;
      $display("FAIL async_restart: got fire %0b addr %h want 1 %h", obs_rfire, obs_addr, RESET_PC);
    end
  endtask

  task automatic test_random();
    int delivered;
    apply_reset();
    lat_lo = 1; lat_hi = 4;
    delivered = 0;
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 29) == 0, $urandom, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0);
      if (obs_ofire) delivered++;
    end
    vectors++;
    if (delivered < 100) begin
      miscompares++;
      $display("FAIL random_progress: got %0d deliveries want at least 100", delivered);
    end
  endtask

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    vectors = 0; miscompares = 0; cyc = 0; last_due = 0;
    special_en = 1'b0; special_addr = 32'h0; hold = 1'b0; exp_fetch = RESET_PC;
    lat_lo = 1; lat_hi = 1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_stale();
    test_redirect_collide();
    test_wrap();
`ifdef RISCV_FETCH_BRANCH_STALL_EN
    test_branch_stall();
`endif
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
